// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch queue.
package fetch_pkg;

  // One queue slot: request metadata captured at issue, instruction captured at fill.
  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic [31:0] instr;
    logic        filled;
  } fq_entry_t;

  // Canonical bubble instruction (addi x0, x0, 0) that decode substitutes when out_valid is low.
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // Width of a pointer that indexes DEPTH entries; at least one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Sequential successor of a PC, wrapping at 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fq_storage.sv
// DEPTH-entry register array for the fetch queue: one allocate port, one fill port,
// one clear port and a read port at the head. A flush clears every slot.
module fq_storage
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = ptr_w(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            alloc_we,
  input  logic [PW-1:0]   alloc_idx,
  input  logic [31:0]     alloc_pc,
  input  logic            alloc_pred_taken,
  input  logic [31:0]     alloc_pred_pc,
  input  logic            fill_we,
  input  logic [PW-1:0]   fill_idx,
  input  logic [31:0]     fill_instr,
  input  logic            clr_we,
  input  logic [PW-1:0]   clr_idx,
  input  logic [PW-1:0]   rd_idx,
  output fq_entry_t       rd_entry
);

  fq_entry_t mem_q [DEPTH];
  fq_entry_t mem_d [DEPTH];

  // Next contents of every slot; the control logic never targets one slot with two ports.
  always_comb begin
    mem_d = mem_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
    end else begin
      if (clr_we) mem_d[clr_idx] = '0;
      if (alloc_we) begin
        mem_d[alloc_idx] = '{pc: alloc_pc, pred_taken: alloc_pred_taken,
                             pred_pc: alloc_pred_pc, instr: '0, filled: 1'b0};
      end
      if (fill_we) begin
        mem_d[fill_idx].instr  = fill_instr;
        mem_d[fill_idx].filled = 1'b1;
      end
    end
  end

  // Slot registers, cleared on reset so every entry starts invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_entry = mem_q[rd_idx];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues in-order imem requests steered by
// the branch predictor, buffers responses with their metadata and hands them to decode.
// A redirect flushes the queue and counts still-outstanding responses so they are discarded.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic [31:0] pred_pc,
  input  logic        pred_taken,
  output logic [31:0] fetch_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        out_pred_taken,
  output logic [31:0] out_pred_pc
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = $clog2(MAX_OUT + 1);

  logic [PW-1:0] alloc_q, alloc_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [PW-1:0] head_q, head_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [DW-1:0] drop_cnt_q, drop_cnt_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;

  fq_entry_t     head_entry;
  logic [31:0]   outstanding;
  logic          issue;
  logic          rsp_fill;
  logic          rsp_drop;
  logic          pop;

  // Every imem request not yet answered, whether it will be kept or dropped.
  assign outstanding = 32'(inflight_q) + 32'(drop_cnt_q);

  // rst gating keeps the request line quiet while the block is held in reset.
  assign imem_req_valid = rst && !redirect && (occ_q < CW'(DEPTH)) &&
                          (outstanding < 32'(MAX_OUT));
  assign imem_req_addr  = fetch_pc_q;
  assign fetch_pc       = fetch_pc_q;

  assign issue    = imem_req_valid && imem_req_ready;
  assign rsp_drop = imem_rsp_valid && (drop_cnt_q != '0);
  // A response with nothing outstanding is a protocol error and is simply ignored.
  assign rsp_fill = imem_rsp_valid && (drop_cnt_q == '0) && (inflight_q != '0);

  assign out_valid = !redirect && (occ_q != '0) && head_entry.filled;
  assign pop       = out_valid && out_ready;

  // Outputs read registered storage only, and read as zero whenever nothing is presented.
  assign out_instr      = out_valid ? head_entry.instr      : '0;
  assign out_pc         = out_valid ? head_entry.pc         : '0;
  assign out_pc_plus4   = out_valid ? pc_plus4(head_entry.pc) : '0;
  assign out_pred_taken = out_valid && head_entry.pred_taken;
  assign out_pred_pc    = out_valid ? head_entry.pred_pc    : '0;

  fq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk              (clk),
    .rst              (rst),
    .flush            (redirect),
    .alloc_we         (issue),
    .alloc_idx        (alloc_q),
    .alloc_pc         (fetch_pc_q),
    .alloc_pred_taken (pred_taken),
    .alloc_pred_pc    (pred_pc),
    .fill_we          (rsp_fill && !redirect),
    .fill_idx         (fill_q),
    .fill_instr       (imem_rsp_data),
    .clr_we           (pop),
    .clr_idx          (head_q),
    .rd_idx           (head_q),
    .rd_entry         (head_entry)
  );

  // Pointer, count and fetch-PC update; a redirect overrides everything else in its cycle.
  always_comb begin
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    head_d     = head_q;
    occ_d      = occ_q;
    inflight_d = inflight_q;
    drop_cnt_d = drop_cnt_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      alloc_d    = '0;
      fill_d     = '0;
      head_d     = '0;
      occ_d      = '0;
      inflight_d = '0;
      fetch_pc_d = redirect_pc;
      // A response arriving now retires one outstanding request on its way out.
      drop_cnt_d = DW'(outstanding -
                       ((imem_rsp_valid && (outstanding != 32'd0)) ? 32'd1 : 32'd0));
    end else begin
      if (issue) begin
        alloc_d    = alloc_q + PW'(1);
        fetch_pc_d = pred_pc;
      end
      if (rsp_fill) fill_d = fill_q + PW'(1);
      if (pop)      head_d = head_q + PW'(1);
      if (rsp_drop) drop_cnt_d = drop_cnt_q - DW'(1);
      occ_d      = occ_q + CW'(issue) - CW'(pop);
      inflight_d = inflight_q + CW'(issue) - CW'(rsp_fill);
    end
  end

  // Control registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc_q    <= '0;
      fill_q     <= '0;
      head_q     <= '0;
      occ_q      <= '0;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      head_q     <= head_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Flag a response that arrives while no request is outstanding.
  always_ff @(posedge clk) begin
    if (rst && imem_rsp_valid) assert (outstanding != 32'd0);
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] fetch_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc, out_pc_plus4, out_pred_pc;
  logic        out_pred_taken;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .pred_pc(pred_pc), .pred_taken(pred_taken), .fetch_pc(fetch_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
    .out_pred_taken(out_pred_taken), .out_pred_pc(out_pred_pc)
  );

  // Predictor: one PC slot (pc[6:2] == tk_sel) jumps to tk_tgt, everything else falls through.
  logic        tk_on  = 1'b0;
  logic [4:0]  tk_sel = '0;
  logic [31:0] tk_tgt = '0;
  assign pred_taken = tk_on && (fetch_pc[6:2] == tk_sel);
  assign pred_pc    = pred_taken ? tk_tgt : fetch_pc + 32'd4;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Instruction memory model: in-order, per-request latency, one response per cycle.
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          lat_min = 1, lat_max = 1, rdy_pct = 100;

  // Reference stream: the next PC expected to be requested and to reach decode.
  logic [31:0] exp_req, exp_out;
  logic        iss_seen, pop_seen, pop_tk;
  logic [31:0] iss_addr, pop_pc, pop_instr, pop_ppc;
  int          n_iss, n_pop;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic pred_tk(input logic [31:0] pc);
    logic [4:0] s;
    s = pc[6:2];
    return tk_on && (s == tk_sel);
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pred_tk(pc) ? tk_tgt : pc + 32'd4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive imem, observe the handshakes that happen at the coming edge.
  task automatic step();
    logic rsp_now;
    int   due;
    rsp_now        = (mq_addr.size() > 0) && (mq_due[0] <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? instr_of(mq_addr[0]) : $urandom;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    #1;
    iss_seen = imem_req_valid && imem_req_ready;
    pop_seen = out_valid && out_ready;
    if (redirect) begin
      chk("redirect_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("redirect_out_valid", {31'd0, out_valid}, 32'd0);
    end
    if (iss_seen) begin
      chk("req_addr", imem_req_addr, exp_req);
      chk("max_outstanding", {31'd0, mq_addr.size() < MAX_OUT}, 32'd1);
    end
    if (rsp_now) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (iss_seen) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (mq_due.size() > 0 && mq_due[$] >= due) due = mq_due[$] + 1;
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(due);
      iss_addr = imem_req_addr;
      exp_req  = next_pc(exp_req);
      n_iss++;
    end
    if (pop_seen) begin
      pop_pc    = out_pc;
      pop_instr = out_instr;
      pop_tk    = out_pred_taken;
      pop_ppc   = out_pred_pc;
      chk("out_pc", out_pc, exp_out);
      chk("out_instr", out_instr, instr_of(exp_out));
      chk("out_pc_plus4", out_pc_plus4, exp_out + 32'd4);
      chk("out_pred_taken", {31'd0, out_pred_taken}, {31'd0, pred_tk(exp_out)});
      chk("out_pred_pc", out_pred_pc, next_pc(exp_out));
      exp_out = next_pc(exp_out);
      n_pop++;
    end
    if (redirect) begin
      exp_req = redirect_pc;
      exp_out = redirect_pc;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_model();
    mq_addr.delete();
    mq_due.delete();
    exp_req = RESET_PC;
    exp_out = RESET_PC;
    n_iss   = 0;
    n_pop   = 0;
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    redirect       = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    clear_model();
    @(negedge clk);
    cyc++;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    iss_seen = 1'b0; pop_seen = 1'b0; pop_tk = 1'b0;
    iss_addr = '0; pop_pc = '0; pop_instr = '0; pop_ppc = '0;
    clear_model();
    #2 rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_fetch_pc", fetch_pc, RESET_PC);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc_plus4", out_pc_plus4, 32'd0);

    // Sequential stream, latency 1, no stalls
    do_reset();
    out_ready = 1'b1;
    step(); chk("seq_no_out_c0", {31'd0, pop_seen}, 32'd0);
    step(); chk("seq_no_out_c1", {31'd0, pop_seen}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("seq_pop_valid", {31'd0, pop_seen}, 32'd1);
      chk("seq_pop_pc", pop_pc, 32'(k * 4));
    end

    // Backpressure: queue fills to DEPTH and stops requesting
    do_reset();
    out_ready = 1'b0;
    repeat (10) step();
    chk("bp_issued", 32'(n_iss), 32'(DEPTH));
    chk("bp_req_valid_full", {31'd0, imem_req_valid}, 32'd0);
    chk("bp_out_valid_stall", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp_full_blocks_issue", {31'd0, iss_seen}, 32'd0);
    chk("bp_first_pop", pop_seen ? pop_pc : 32'hFFFF_FFFF, 32'd0);
    repeat (3) step();
    chk("bp_fourth_pop", pop_seen ? pop_pc : 32'hFFFF_FFFF, 32'd12);

    // Redirect with two requests in flight
    do_reset();
    lat_min = 3; lat_max = 3;
    step(); step();
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    step(); chk("rd2_blocked_while_dropping", {31'd0, iss_seen}, 32'd0);
    step(); chk("rd2_issue_after_drops", iss_seen ? iss_addr : 32'hFFFF_FFFF, 32'h100);
    for (int i = 0; i < 30; i++) begin step(); if (pop_seen) break; end
    chk("rd2_pop_seen", {31'd0, pop_seen}, 32'd1);
    chk("rd2_first_pc", pop_pc, 32'h100);
    chk("rd2_first_instr", pop_instr, instr_of(32'h100));

    // Back-to-back redirects
    redirect = 1'b1; redirect_pc = 32'h300; step();
    redirect_pc = 32'h340; step();
    redirect = 1'b0;
    for (int i = 0; i < 30; i++) begin step(); if (pop_seen) break; end
    chk("b2b_first_pc", pop_seen ? pop_pc : 32'hFFFF_FFFF, 32'h340);

    // Redirect in the same cycle as a response
    do_reset();
    lat_min = 2; lat_max = 2;
    step(); step();
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    step(); chk("rdrsp_issue_next", iss_seen ? iss_addr : 32'hFFFF_FFFF, 32'h200);
    for (int i = 0; i < 30; i++) begin step(); if (pop_seen) break; end
    chk("rdrsp_first_pc", pop_seen ? pop_pc : 32'hFFFF_FFFF, 32'h200);

    // Predicted-taken fetch at 0x8 -> 0x40
    tk_on = 1'b1; tk_sel = 5'd2; tk_tgt = 32'h40;
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 20; i++) begin step(); if (pop_seen && pop_pc == 32'h8) break; end
    chk("tk_pop_8", pop_seen ? pop_pc : 32'hFFFF_FFFF, 32'h8);
    chk("tk_pred_taken", {31'd0, pop_tk}, 32'd1);
    chk("tk_pred_pc", pop_ppc, 32'h40);
    step();
    chk("tk_next_pc", pop_seen ? pop_pc : 32'hFFFF_FFFF, 32'h40);

    // Asynchronous reset with three entries queued
    tk_on = 1'b0;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin step(); if (n_iss == 3) break; end
    chk("mid_three_queued", 32'(n_iss), 32'd3);
    imem_rsp_valid = 1'b0;
    #1;
    chk("mid_out_valid_before", {31'd0, out_valid}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_out_valid_async", {31'd0, out_valid}, 32'd0);
    chk("mid_req_valid_async", {31'd0, imem_req_valid}, 32'd0);
    chk("mid_fetch_pc_async", fetch_pc, RESET_PC);
    clear_model();
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    chk("mid_first_req", iss_seen ? iss_addr : 32'hFFFF_FFFF, RESET_PC);

    // Randomized traffic against the reference stream
    tk_on = 1'b1; tk_sel = 5'($urandom_range(31)); tk_tgt = 32'($urandom_range(63)) << 2;
    lat_min = 1; lat_max = 4; rdy_pct = 75;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      out_ready   = ($urandom_range(99) < 70);
      redirect    = ($urandom_range(99) < 4);
      redirect_pc = 32'($urandom_range(255)) << 2;
      step();
    end
    redirect = 1'b0;
    chk("rand_progress", {31'd0, n_pop > 200}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
